decode_stage: RTL

Registered instruction-decode stage between the instruction memory and the `control` unit. Accepts a 32-bit MIPS instruction word and its PC over a valid/ready handshake, decodes it into the 32-bit one-hot instruction vector `i` consumed by `control`, extracts operand fields, and presents them one cycle later through an output register with backpressure. Also records illegal opcodes: a sticky flag, the first offending PC, and a saturating count. Supports a synchronous flush for taken branches and jumps.

---
 rtl/decode_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: one-hot instruction vector, operand fields and
// illegal-opcode logging, behind a valid/ready output register with flush.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [31:0]         in_pc,
  input  logic                flush,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [31:0]         i,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [15:0]         imm16,
  output logic [25:0]         index26,
  output logic [31:0]         dec_pc,
  output logic                illegal,
  output logic                err_sticky,
  output logic [31:0]         err_pc,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         inst_q, pc_q, i_q;
  logic                illegal_q;
  logic                err_sticky_q, err_sticky_d;
  logic [31:0]         err_pc_q, err_pc_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]         in_onehot;
  logic                in_illegal, accept, log_err;

  function automatic logic [31:0] decode_inst(input logic [31:0] inst);
    logic [31:0] v;
    v = '0;
    case (inst[31:26])
      6'h00: begin
        case (inst[5:0])
          6'h20: v[0]  = 1'b1;
          6'h21: v[1]  = 1'b1;
          6'h22: v[2]  = 1'b1;
          6'h23: v[3]  = 1'b1;
          6'h24: v[4]  = 1'b1;
          6'h25: v[5]  = 1'b1;
          6'h26: v[6]  = 1'b1;
          6'h27: v[7]  = 1'b1;
          6'h2A: v[8]  = 1'b1;
          6'h2B: v[9]  = 1'b1;
          6'h00: v[10] = 1'b1;
          6'h02: v[11] = 1'b1;
          6'h03: v[12] = 1'b1;
          6'h04: v[13] = 1'b1;
          6'h06: v[14] = 1'b1;
          6'h07: v[15] = 1'b1;
          6'h08: v[16] = 1'b1;
          default: v = '0;
        endcase
      end
      6'h08: v[17] = 1'b1;
      6'h09: v[18] = 1'b1;
      6'h0C: v[19] = 1'b1;
      6'h0D: v[20] = 1'b1;
      6'h0E: v[21] = 1'b1;
      6'h23: v[22] = 1'b1;
      6'h2B: v[23] = 1'b1;
      6'h04: v[24] = 1'b1;
      6'h05: v[25] = 1'b1;
      6'h0A: v[26] = 1'b1;
      6'h0B: v[27] = 1'b1;
      6'h0F: v[28] = 1'b1;
      6'h02: v[29] = 1'b1;
      6'h03: v[30] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign in_onehot  = decode_inst(in_inst);
  assign in_illegal = (in_onehot == '0);
  assign in_ready   = !dec_valid | dec_ready;
  // Flush wins over a simultaneous accept, so a squashed word never logs an error.
  assign accept     = in_valid & in_ready & !flush;
  assign log_err    = accept & in_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = EMPTY;
    else if (accept)    state_d = FULL;
    else if (dec_ready) state_d = EMPTY;
  end

  always_comb begin
    dec_valid = (state_q == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q    <= '0;
      pc_q      <= RESET_PC;
      i_q       <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      inst_q    <= in_inst;
      pc_q      <= in_pc;
      i_q       <= in_onehot;
      illegal_q <= in_illegal;
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q | log_err;
    err_pc_d     = (log_err && !err_sticky_q) ? in_pc : err_pc_q;
    err_count_d  = err_count_q;
    if (log_err && (err_count_q != '1)) err_count_d = err_count_q + ERRCNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_pc_q     <= RESET_PC;
      err_count_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_pc_q     <= err_pc_d;
      err_count_q  <= err_count_d;
    end
  end

  assign i          = i_q;
  assign illegal    = illegal_q;
  assign rs         = inst_q[25:21];
  assign rt         = inst_q[20:16];
  assign rd         = inst_q[15:11];
  assign shamt      = inst_q[10:6];
  assign imm16      = inst_q[15:0];
  assign index26    = inst_q[25:0];
  assign dec_pc     = pc_q;
  assign err_sticky = err_sticky_q;
  assign err_pc     = err_pc_q;
  assign err_count  = err_count_q;

endmodule
